// File: rtl/render_scan_ctrl_pkg.sv
// Chunk codes, default 640x480@60 timing and the stage-1 pipeline record shared with the renderer.
// TILE_GRID_EN adds the two tile-edge flags to the stage-1 record.
package render_scan_ctrl_pkg;

  typedef enum logic [3:0] {
    PLAYER_UP    = 4'd0,
    PLAYER_DOWN  = 4'd1,
    PLAYER_LEFT  = 4'd2,
    PLAYER_RIGHT = 4'd3,
    BOX          = 4'd4,
    TARGET       = 4'd5,
    WALL         = 4'd6,
    GROUND       = 4'd7,
    SIDE         = 4'd8
  } chunk_e;

  localparam int DEF_H_ACTIVE   = 640;
  localparam int DEF_H_FP       = 16;
  localparam int DEF_H_SYNC     = 96;
  localparam int DEF_H_BP       = 48;
  localparam int DEF_V_ACTIVE   = 480;
  localparam int DEF_V_FP       = 10;
  localparam int DEF_V_SYNC     = 2;
  localparam int DEF_V_BP       = 33;
  localparam int DEF_TILE_SHIFT = 5;
  localparam int DEF_MAP_W      = 16;
  localparam int DEF_MAP_H      = 12;
  localparam int DEF_ADDR_W     = 8;

  // Wide enough for 800 columns and 525 lines.
  localparam int CNT_W = 10;

  localparam logic [11:0] GRID_RGB  = 12'h222;
  localparam logic [11:0] BLANK_RGB = 12'h000;

  typedef struct packed {
    logic vld;
    logic active;
    logic in_map;
    logic hs;
    logic vs;
`ifdef TILE_GRID_EN
    logic grid_x;
    logic grid_y;
`endif
  } s1_t;

  function automatic s1_t s1_idle();
    s1_t s;
    s    = '0;
    s.hs = 1'b1;
    s.vs = 1'b1;
    return s;
  endfunction

endpackage

// File: rtl/render_scan_ctrl_vga_timing.sv
// Raster counters stepped by the pixel strobe, with active-area and raw active-low sync decode.
// Counters freeze while pix_en is low; frame_start is a combinational strobe at (0,0).
module vga_timing
  import render_scan_ctrl_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             active,
  output logic             hs_raw,
  output logic             vs_raw,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic h_wrap;
  logic v_wrap;

  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      h_cnt <= h_wrap ? '0 : h_cnt + CNT_W'(1);
      if (h_wrap) begin
        v_cnt <= v_wrap ? '0 : v_cnt + CNT_W'(1);
      end
    end
  end

  assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_raw = ~((h_cnt >= HS_BEG) && (h_cnt < HS_END));
  assign vs_raw = ~((v_cnt >= VS_BEG) && (v_cnt < VS_END));

  // Gated by rst so no pulse escapes while the counters are being held at zero.
  assign frame_start = pix_en && !rst && (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: rtl/render_scan_ctrl.sv
// Raster scan controller: map-RAM tile addressing, chunk hand-off to the renderer, VGA pin alignment.
// Colour and sync reach the pins 2 pix_en ticks after the counter position; all state holds while pix_en is low. TILE_GRID_EN overlays a tile grid.
module render_scan_ctrl
  import render_scan_ctrl_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int TILE_SHIFT = DEF_TILE_SHIFT,
  parameter int MAP_W      = DEF_MAP_W,
  parameter int MAP_H      = DEF_MAP_H,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_en,
  output logic [ADDR_W-1:0] map_addr,
  input  logic [3:0]        map_data,
  output logic [3:0]        chunk_type,
  input  logic [11:0]       rgb_in,
  output logic [11:0]       vga_rgb,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              frame_start
);

  localparam logic [CNT_W-1:0] MAP_W_C = CNT_W'(MAP_W);
  localparam logic [CNT_W-1:0] MAP_H_C = CNT_W'(MAP_H);

  logic [CNT_W-1:0]  h_cnt;
  logic [CNT_W-1:0]  v_cnt;
  logic              active;
  logic              hs_raw;
  logic              vs_raw;
  logic [CNT_W-1:0]  tile_x;
  logic [CNT_W-1:0]  tile_y;
  logic              in_map;
  logic [ADDR_W-1:0] map_addr_nxt;
  s1_t               s1_d;
  s1_t               s1_q;
  logic [11:0]       rgb_nxt;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .pix_en      (pix_en),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .active      (active),
    .hs_raw      (hs_raw),
    .vs_raw      (vs_raw),
    .frame_start (frame_start)
  );

  assign tile_x       = h_cnt >> TILE_SHIFT;
  assign tile_y       = v_cnt >> TILE_SHIFT;
  assign in_map       = active && (tile_x < MAP_W_C) && (tile_y < MAP_H_C);
  assign map_addr_nxt = ADDR_W'(tile_y * MAP_W_C + tile_x);

  always_comb begin
    s1_d        = '0;
    s1_d.vld    = 1'b1;
    s1_d.active = active;
    s1_d.in_map = in_map;
    s1_d.hs     = hs_raw;
    s1_d.vs     = vs_raw;
`ifdef TILE_GRID_EN
    s1_d.grid_x = (h_cnt[TILE_SHIFT-1:0] == '0);
    s1_d.grid_y = (v_cnt[TILE_SHIFT-1:0] == '0);
`endif
  end

  // Off-map pixels keep the previous address so the RAM read port stays quiet.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= s1_idle();
      map_addr <= '0;
    end else if (pix_en) begin
      s1_q <= s1_d;
      if (in_map) begin
        map_addr <= map_addr_nxt;
      end
    end
  end

  assign chunk_type = s1_q.in_map ? map_data : 4'(SIDE);

  always_comb begin
    rgb_nxt = BLANK_RGB;
    if (s1_q.vld && s1_q.active) begin
      rgb_nxt = rgb_in;
`ifdef TILE_GRID_EN
      if (s1_q.in_map && (s1_q.grid_x || s1_q.grid_y)) begin
        rgb_nxt = GRID_RGB;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vga_rgb <= BLANK_RGB;
      vga_hs  <= 1'b1;
      vga_vs  <= 1'b1;
    end else if (pix_en) begin
      vga_rgb <= rgb_nxt;
      vga_hs  <= s1_q.hs;
      vga_vs  <= s1_q.vs;
    end
  end

endmodule

// File: tb/tb_render_scan_ctrl.sv
// Scoreboard bench for render_scan_ctrl on a shrunken raster (96x67 total, 4-px tiles).
// Honours TILE_GRID_EN in its expected colours.
module tb_render_scan_ctrl;

  localparam int HA = 80, HF = 4, HSY = 8, HB = 4;
  localparam int VA = 60, VF = 2, VSY = 2, VB = 3;
  localparam int TS = 2, MW = 16, MH = 12, AW = 8;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam logic [3:0] SIDE_C = 4'd8;
`ifdef TILE_GRID_EN
  localparam bit GRID = 1'b1;
`else
  localparam bit GRID = 1'b0;
`endif

  typedef struct {
    int          x;
    int          y;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pix_en = 1'b0;
  logic [AW-1:0] map_addr;
  logic [3:0]    map_data = 4'd0;
  logic [3:0]    chunk_type;
  logic [11:0]   rgb_in = 12'h000;
  logic [11:0]   vga_rgb;
  logic          vga_hs;
  logic          vga_vs;
  logic          frame_start;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  exp_t me;
  exp_t last_exp;
  logic [11:0] dir_exp;
  int   hs_run = 0;
  int   vs_run = 0;
  int   h = 0;
  int   v = 0;
  logic [7:0] m_addr = 8'd0;
  logic [3:0] m_chunk = 4'd8;

  render_scan_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .TILE_SHIFT(TS), .MAP_W(MW), .MAP_H(MH), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .map_addr(map_addr), .map_data(map_data), .chunk_type(chunk_type),
    .rgb_in(rgb_in), .vga_rgb(vga_rgb), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] col(input logic [3:0] c);
    return (c == 4'd8) ? 12'h222 : {c, 4'hA, ~c};
  endfunction

  // Map RAM returns addr[3:0]; renderer registers a colour per code.
  always @(posedge clk) begin
    map_data <= map_addr[3:0];
    rgb_in   <= col(chunk_type);
  end

  task automatic chk(input string name, input int x, input int y,
                     input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s at (%0d,%0d): got %0h expected %0h", name, x, y, act, expv);
    end
  endtask

  function automatic bit dir_rgb(input int x, input int y, output logic [11:0] r);
    bit hit;
    hit = 1'b1;
    r   = 12'h000;
    if (x == 5 && y == 1)        r = 12'h1AE;
    else if (x == 1 && y == 5)   r = 12'h0AF;
    else if (x == 63 && y == 47) r = 12'hFA0;
    else if (x == 64 && y == 0)  r = 12'h222;
    else if (x == 1 && y == 48)  r = 12'h222;
    else if (x == 85 && y == 3)  r = 12'h000;
    else if (x == 4 && y == 1)   r = GRID ? 12'h222 : 12'h1AE;
    else hit = 1'b0;
    return hit;
  endfunction

  always @(posedge clk) begin
    if (pix_en && !rst) begin
      #1;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pin_queue: DUT ticked with no expectation queued");
      end else begin
        me = exp_q.pop_front();
        last_exp = me;
        chk("vga_rgb", me.x, me.y, 32'(vga_rgb), 32'(me.rgb));
        chk("vga_hs", me.x, me.y, 32'(vga_hs), 32'(me.hs));
        chk("vga_vs", me.x, me.y, 32'(vga_vs), 32'(me.vs));
        if (dir_rgb(me.x, me.y, dir_exp))
          chk("dir_rgb", me.x, me.y, 32'(vga_rgb), 32'(dir_exp));
        if (!vga_hs) hs_run++;
        else if (hs_run != 0) begin
          chk("hs_width", me.x, me.y, 32'(hs_run), 32'(HSY));
          hs_run = 0;
        end
        if (!vga_vs) vs_run++;
        else if (vs_run != 0) begin
          chk("vs_width", me.x, me.y, 32'(vs_run), 32'(VSY * HT));
          vs_run = 0;
        end
      end
    end
  end

  task automatic do_reset();
    exp_t b;
    @(negedge clk);
    rst    = 1'b1;
    pix_en = 1'b0;
    @(negedge clk);
    pix_en = 1'b1;
    #1;
    chk("rst_frame_start", h, v, 32'(frame_start), 32'd0);
    @(negedge clk);
    pix_en = 1'b0;
    @(negedge clk);
    chk("rst_rgb", h, v, 32'(vga_rgb), 32'h000);
    chk("rst_hs", h, v, 32'(vga_hs), 32'd1);
    chk("rst_vs", h, v, 32'(vga_vs), 32'd1);
    chk("rst_map_addr", h, v, 32'(map_addr), 32'd0);
    chk("rst_chunk", h, v, 32'(chunk_type), 32'(SIDE_C));
    rst    = 1'b0;
    h      = 0;
    v      = 0;
    m_addr = 8'd0;
    m_chunk = SIDE_C;
    hs_run = 0;
    vs_run = 0;
    exp_q.delete();
    b.x = -1; b.y = -1; b.rgb = 12'h000; b.hs = 1'b1; b.vs = 1'b1;
    exp_q.push_back(b);
  endtask

  task automatic tick(input int period);
    exp_t e;
    int   tx, ty;
    bit   act, inm, grid;
    act  = (h < HA) && (v < VA);
    tx   = h >> TS;
    ty   = v >> TS;
    inm  = act && (tx < MW) && (ty < MH);
    grid = ((h % (1 << TS)) == 0) || ((v % (1 << TS)) == 0);
    if (inm) m_addr = 8'(ty * MW + tx);
    m_chunk = inm ? m_addr[3:0] : SIDE_C;
    e.x  = h;
    e.y  = v;
    e.hs = !((h >= HA + HF) && (h < HA + HF + HSY));
    e.vs = !((v >= VA + VF) && (v < VA + VF + VSY));
    if (!act) e.rgb = 12'h000;
    else if (GRID && inm && grid) e.rgb = 12'h222;
    else e.rgb = col(m_chunk);
    exp_q.push_back(e);

    pix_en = 1'b1;
    #1;
    chk("frame_start", h, v, 32'(frame_start), (h == 0 && v == 0) ? 32'd1 : 32'd0);
    @(posedge clk);
    @(negedge clk);
    pix_en = 1'b0;
    chk("map_addr", h, v, 32'(map_addr), 32'(m_addr));
    if (h == 5 && v == 1)   chk("dir_addr", h, v, 32'(map_addr), 32'd1);
    if (h == 1 && v == 5)   chk("dir_addr", h, v, 32'(map_addr), 32'd16);
    if (h == 63 && v == 47) chk("dir_addr", h, v, 32'(map_addr), 32'd191);
    @(negedge clk);
    chk("chunk_type", h, v, 32'(chunk_type), 32'(m_chunk));
    if (h == 5 && v == 1)  chk("dir_chunk", h, v, 32'(chunk_type), 32'd1);
    if (h == 64 && v == 0) chk("dir_chunk", h, v, 32'(chunk_type), 32'd8);
    if (h == 1 && v == 48) chk("dir_chunk", h, v, 32'(chunk_type), 32'd8);
    repeat (period - 2) @(negedge clk);

    if (h == HT - 1) begin
      h = 0;
      v = (v == VT - 1) ? 0 : v + 1;
    end else begin
      h++;
    end
  endtask

  task automatic stall(input int n);
    repeat (n) @(negedge clk);
    chk("stall_rgb", last_exp.x, last_exp.y, 32'(vga_rgb), 32'(last_exp.rgb));
    chk("stall_hs", last_exp.x, last_exp.y, 32'(vga_hs), 32'(last_exp.hs));
    chk("stall_vs", last_exp.x, last_exp.y, 32'(vga_vs), 32'(last_exp.vs));
    chk("stall_map_addr", h, v, 32'(map_addr), 32'(m_addr));
    chk("stall_chunk", h, v, 32'(chunk_type), 32'(m_chunk));
  endtask

  initial begin
    do_reset();
    for (int i = 0; i < 40; i++) tick(4);
    do_reset();
    for (int i = 0; i < HT * VT + 200; i++) begin
      bit st;
      st = (h == 30 && v == 5);
      tick(3);
      if (st) stall(100);
    end
    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/render_scan_ctrl.md
Name: render_scan_ctrl

Overview:
Raster scan controller that sequences the chunk renderer for the Sokoban VGA display.
- Generates 640x480@60 timing from a pixel strobe and converts pixel position into a map-RAM tile address.
- Forwards the fetched chunk code to the renderer, captures the returned 12-bit colour, and aligns it with delayed HS/VS/blanking at the VGA pins.
- Sits between the map RAM, the chunk renderer and the VGA connector.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, hsync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch
V_SYNC, 2, vsync width
V_BP, 33, vertical back porch
TILE_SHIFT, 5, log2 of tile edge in pixels (32 px)
MAP_W, 16, map width in tiles
MAP_H, 12, map height in tiles
ADDR_W, 8, map RAM address width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
pix_en  in  1  pixel strobe, one clk wide, period >= 3 clk (default 4)
map_addr  out  ADDR_W  map RAM read address, 1-clk read latency RAM
map_data  in  4  chunk code from map RAM
chunk_type  out  4  chunk code to renderer
rgb_in  in  12  colour from renderer, 1 clk after chunk_type
vga_rgb  out  12  {R,G,B} 4 bits each to DAC
vga_hs  out  1  hsync, active low
vga_vs  out  1  vsync, active low
frame_start  out  1  one-clk pulse at first pix_en of pixel (0,0)

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - h_cnt=0, v_cnt=0, map_addr=0.
  - chunk_type=SIDE, vga_rgb=0, vga_hs=1, vga_vs=1, frame_start=0.
  - Pipeline valid bits cleared.
- Counters:
  - All counters and pipeline registers advance only on pix_en.
  - h_cnt counts 0..H_TOTAL-1, where H_TOTAL = sum of the four H parameters (800). On wrap, v_cnt increments.
  - v_cnt counts 0..V_TOTAL-1 (525) and wraps to 0.
  - Both wrap on the same pix_en at (799,524).
- Stage 0, pix_en tick k, pixel (h,v):
  - active = h<H_ACTIVE && v<V_ACTIVE.
  - tile_x = h>>TILE_SHIFT, tile_y = v>>TILE_SHIFT.
  - in_map = active && tile_x<MAP_W && tile_y<MAP_H.
  - map_addr is registered as tile_y*MAP_W + tile_x (truncated to ADDR_W), else holds its last value.
  - s1_in_map, s1_active, s1_hs and s1_vs are registered.
  - hs_raw is low while H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; vs_raw follows the same rule for v.
- Between strobes:
  - chunk_type is combinational: map_data when s1_in_map, else the SIDE code.
  - The renderer registers the colour one clk later, so rgb_in is valid before tick k+1 given pix_en period >= 3.
- Stage 1, tick k+1:
  - vga_rgb <= s1_active ? rgb_in : 0.
  - vga_hs <= s1_hs, vga_vs <= s1_vs.
  - Total latency from counter position to pins is 2 pix_en ticks, identical for colour and sync.
- frame_start: asserted for the single clk in which pix_en=1 and h_cnt=0, v_cnt=0 (stage 0).
- pix_en held low: all state freezes and outputs hold.
- Reset mid-frame: next pix_en after release restarts at (0,0). Outputs are blanked with sync deasserted until the pipeline refills (2 ticks).
- Unknown map codes pass through unchanged; colour policy belongs to the renderer.

Optional Feature:
TILE_GRID_EN
- Defined: at stage 1, pixels with in_map and (h[TILE_SHIFT-1:0]==0 or v[TILE_SHIFT-1:0]==0) are output as 12'h222 instead of rgb_in. The two low-bit flags are carried down the pipeline alongside the valid bits.
- Undefined: no grid, and the extra pipeline bits are absent.

Decomposition:
- Shared package: chunk codes (PLAYER_UP, PLAYER_DOWN, PLAYER_LEFT, PLAYER_RIGHT, BOX, TARGET, WALL, GROUND, SIDE) and default VGA timing constants. The renderer includes the same package.
- Sub-module vga_timing: h/v counters, active, hs_raw, vs_raw, frame_start. render_scan_ctrl holds address generation and pipeline alignment.

Test Plan:
- Reset: assert rst 3 clk mid-line -> all outputs at reset values. First pix_en after release gives frame_start=1 and h=v=0.
- Addressing: pixel (32,0) -> map_addr=1; (0,32) -> 16; (511,383) -> 191. With map RAM model data=addr[3:0], vga_rgb 2 ticks later equals renderer colour for that code.
- Off-map: pixel (512,0) and (0,384) -> chunk_type=SIDE; vga_rgb=12'h222 from renderer.
- Sync: vga_hs low for exactly 96 ticks starting at pin-tick 656+2; vga_vs low for exactly 2 lines starting at line 490; vga_rgb=0 for h>=640.
- Stall: hold pix_en low 100 clk mid-line -> outputs and map_addr unchanged; resumes with next pixel.
- TILE_GRID_EN build: pixel (32,5) -> 12'h222; (33,5) -> renderer colour. Non-grid build: (32,5) -> renderer colour.
